// File: rtl/mult_sequencer.sv
// mult_sequencer: control sequencer for an add/shift signed multiplier.
// The datapath holds accumulator A, sign-extension bit X, and multiplier
// register B. This block drives the register strobes for that datapath.
// One START cycle clears A/X. Then, for each of WIDTH multiplier bits, an
// ADD cycle conditionally loads A+S or A-S, and a SHIFT cycle shifts X:A:B
// right arithmetically. The A-S form is used only on the final (sign) bit.
// Optional build macro: MULT_SEQ_SKIP_EN. When it is defined, the ADD cycle
// is skipped whenever M is 0 in the cycle that would otherwise enter ADD.
// This shortens a run to 1 + WIDTH + (number of ADD cycles).
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic reset,
  input  logic ClearA_LoadB,
  input  logic Execute,
  input  logic M,
  output logic ClearA,
  output logic LoadB,
  output logic LoadA,
  output logic Sub,
  output logic Shift_en,
  output logic Busy,
  output logic Done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_last;
  logic              w_req_clr;

  assign w_last    = (r_cnt == LAST);
  // Execute wins over a load request arriving in the same IDLE cycle.
  assign w_req_clr = ClearA_LoadB & ~Execute;

  // State and iteration counter registers; reset aborts any run in progress.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and Moore output decode (LoadA/Sub also see M; IDLE strobes see inputs).
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    ClearA     = 1'b0;
    LoadB      = 1'b0;
    LoadA      = 1'b0;
    Sub        = 1'b0;
    Shift_en   = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        ClearA = w_req_clr;
        LoadB  = w_req_clr;
        if (Execute) begin
          w_next = S_START;
        end
      end
      S_START: begin
        ClearA     = 1'b1;
        Busy       = 1'b1;
        w_cnt_next = '0;
`ifdef MULT_SEQ_SKIP_EN
        w_next     = M ? S_ADD : S_SHIFT;
`else
        w_next     = S_ADD;
`endif
      end
      S_ADD: begin
        // The last multiplier bit carries negative weight, so it subtracts.
        LoadA  = M;
        Sub    = M & w_last;
        Busy   = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        Shift_en = 1'b1;
        Busy     = 1'b1;
        if (w_last) begin
          w_next = S_HOLD;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
`ifdef MULT_SEQ_SKIP_EN
          w_next     = M ? S_ADD : S_SHIFT;
`else
          w_next     = S_ADD;
`endif
        end
      end
      S_HOLD: begin
        // Wait for Execute to fall so that one level equals one multiply.
        Done = 1'b1;
        if (!Execute) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

endmodule
